// File: rtl/shifter_arbiter.sv
// shifter_arbiter
// Shares one shifter unit between the execute stage (requester 0) and a
// multi-cycle helper (requester 1). Round-robin grant, one operation in
// flight, and enable sequencing that works for both barrel and bit-serial
// shifter builds. The result returns on a valid/ready response port.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; o_req_ready may be high
// LOAD  | o_sh_en high for one cycle with latched operands on o_sh_*
// WAIT  | bit-serial only: enable follows busy, capture when busy drops
// DONE  | response valid, held until i_rsp_ready

module shifter_arbiter #(
   parameter logic COMB_SHIFTER = 1'b0
) (
   input  logic        i_clk_n,
   input  logic        i_rst,
   input  logic [1:0]  i_req_valid,
   input  logic [31:0] i_req_a0,
   input  logic [31:0] i_req_a1,
   input  logic [4:0]  i_req_b0,
   input  logic [4:0]  i_req_b1,
   input  logic [2:0]  i_req_funct3_0,
   input  logic [2:0]  i_req_funct3_1,
   input  logic [1:0]  i_req_alt,
   output logic [1:0]  o_req_ready,
   output logic        o_rsp_valid,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_data,
   input  logic        i_rsp_ready,
   output logic [31:0] o_sh_in_a,
   output logic [4:0]  o_sh_in_b,
   output logic [2:0]  o_sh_funct3,
   output logic        o_sh_op_alt,
   output logic        o_sh_en,
   input  logic [31:0] i_sh_result,
   input  logic        i_sh_busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   logic [1:0]  state_q, state_d;
   // rr_q holds the last winner; seen_q stays 0 until the first grant so
   // requester 0 wins the very first tie after reset.
   logic        rr_q, rr_d;
   logic        seen_q, seen_d;
   logic [31:0] a_q, a_d;
   logic [4:0]  b_q, b_d;
   logic [2:0]  f3_q, f3_d;
   logic        alt_q, alt_d;
   logic        id_q, id_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic        win;
   logic [1:0]  req_ready;
   logic        hs;
   logic [31:0] sel_a;
   logic [4:0]  sel_b;
   logic [2:0]  sel_f3;
   logic        sel_alt;
   logic        sel_legal;

   // pick the winning requester: single valid wins, ties go to the one not granted last
   always_comb begin
      win = 1'b0;
      case (i_req_valid)
         2'b10:   win = 1'b1;
         2'b11:   win = seen_q ? ~rr_q : 1'b0;
         default: win = 1'b0;
      endcase
   end

   // ready only in IDLE; held low while reset is asserted so every output reads 0
   assign req_ready = ((state_q == ST_IDLE) && !i_rst && (i_req_valid != 2'b00))
                      ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign hs        = |(i_req_valid & req_ready);

   assign sel_a     = win ? i_req_a1 : i_req_a0;
   assign sel_b     = win ? i_req_b1 : i_req_b0;
   assign sel_f3    = win ? i_req_funct3_1 : i_req_funct3_0;
   assign sel_alt   = win ? i_req_alt[1] : i_req_alt[0];
   assign sel_legal = (sel_f3 == F3_SLL) || (sel_f3 == F3_SR);

   // sequencing: latch on handshake, drive shifter, capture result, hand back
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      seen_d     = seen_q;
      a_d        = a_q;
      b_d        = b_q;
      f3_d       = f3_q;
      alt_d      = alt_q;
      id_d       = id_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               a_d    = sel_a;
               b_d    = sel_b;
               f3_d   = sel_f3;
               alt_d  = sel_alt;
               id_d   = win;
               rr_d   = win;
               seen_d = 1'b1;
               if (sel_legal) begin
                  state_d = ST_LOAD;
               end else begin
                  // unsupported function: pass A straight back, shifter never enabled
                  rsp_data_d = sel_a;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            if (COMB_SHIFTER) begin
               rsp_data_d = i_sh_result;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!i_sh_busy) begin
               rsp_data_d = i_sh_result;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and operand registers; reset drops any operation in flight
   always_ff @(posedge i_clk_n or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         rr_q       <= 1'b0;
         seen_q     <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 5'd0;
         f3_q       <= 3'd0;
         alt_q      <= 1'b0;
         id_q       <= 1'b0;
         rsp_data_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         seen_q     <= seen_d;
         a_q        <= a_d;
         b_q        <= b_d;
         f3_q       <= f3_d;
         alt_q      <= alt_d;
         id_q       <= id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // enable: one pulse in LOAD, then follow busy so it is already 0 in the
   // cycle busy falls (a high enable with busy low would reload the shifter)
   always_comb begin
      o_sh_en = 1'b0;
      case (state_q)
         ST_LOAD: o_sh_en = 1'b1;
         ST_WAIT: o_sh_en = i_sh_busy;
         default: o_sh_en = 1'b0;
      endcase
   end

   assign o_req_ready = req_ready;
   assign o_rsp_valid = (state_q == ST_DONE);
   assign o_rsp_id    = id_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_sh_in_a   = a_q;
   assign o_sh_in_b   = b_q;
   assign o_sh_funct3 = f3_q;
   assign o_sh_op_alt = alt_q;

endmodule
